// File: rtl/wb_pkg.sv
// Shared constants for the write-back arbiter: register-file geometry and
// the grant encoding, which is also the encoding of the round-robin LAST bit.
package wb_pkg;
  localparam int NUM_REG = 8;
  localparam int DATA_W  = 16;
  localparam int REG_W   = 3;

  localparam logic GNT_EX = 1'b0;
  localparam logic GNT_LD = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// the most recent transfer is granted; LAST only moves when advance is high.
module rr_arb2 (
  input  logic       CLK_WB,
  input  logic       RESET_N,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  import wb_pkg::*;

  logic last;

  always_ff @(posedge CLK_WB) begin
    if (!RESET_N) begin
      last <= GNT_LD;
    end else if (advance) begin
      last <= gnt[GNT_LD] ? GNT_LD : GNT_EX;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req[GNT_EX] && req[GNT_LD]) begin
      if (last == GNT_EX) gnt[GNT_LD] = 1'b1;
      else                gnt[GNT_EX] = 1'b1;
    end else if (req[GNT_EX]) begin
      gnt[GNT_EX] = 1'b1;
    end else if (req[GNT_LD]) begin
      gnt[GNT_LD] = 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between the execute
// and load units, and keeps the per-register pending scoreboard for decode.
module wb_arbiter #(
  parameter int NUM_REG = wb_pkg::NUM_REG,
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int REG_W   = $clog2(NUM_REG)
) (
  input  logic               CLK_WB,
  input  logic               RESET_N,
  input  logic               EX_VALID,
  input  logic [REG_W-1:0]   EX_REG,
  input  logic [DATA_W-1:0]  EX_DATA,
  output logic               EX_READY,
  input  logic               LD_VALID,
  input  logic [REG_W-1:0]   LD_REG,
  input  logic [DATA_W-1:0]  LD_DATA,
  output logic               LD_READY,
  input  logic               ISSUE_VALID,
  input  logic [REG_W-1:0]   ISSUE_REG,
  output logic               ISSUE_STALL,
  output logic [NUM_REG-1:0] PENDING,
  output logic [REG_W-1:0]   N_REG,
  output logic [DATA_W-1:0]  REG_IN,
  output logic               REG_WEN
);
  import wb_pkg::*;

  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               xfer;
  logic [NUM_REG-1:0] set_mask;
  logic [NUM_REG-1:0] clr_mask;

  // Handshake: a producer holds VALID/REG/DATA stable until it sees READY;
  // a transfer is VALID & READY at a CLK_WB edge. READY depends only on the
  // VALIDs and LAST, never on REG/DATA, and is forced low during reset.
  assign req[GNT_EX] = RESET_N & EX_VALID;
  assign req[GNT_LD] = RESET_N & LD_VALID;

  rr_arb2 u_arb (
    .CLK_WB  (CLK_WB),
    .RESET_N (RESET_N),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign EX_READY    = gnt[GNT_EX];
  assign LD_READY    = gnt[GNT_LD];
  assign xfer        = |gnt;
  assign ISSUE_STALL = RESET_N & ISSUE_VALID & PENDING[ISSUE_REG];

  // Stall uses the pre-clear PENDING, so a same-edge set and clear of one
  // register only arises from a protocol error; set is applied last and wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ISSUE_VALID && !ISSUE_STALL) set_mask[ISSUE_REG] = 1'b1;
    if (REG_WEN)                     clr_mask[N_REG]     = 1'b1;
  end

  always_ff @(posedge CLK_WB) begin
    if (!RESET_N) begin
      N_REG   <= '0;
      REG_IN  <= '0;
      REG_WEN <= 1'b0;
      PENDING <= '0;
    end else begin
      REG_WEN <= xfer;
      if (xfer) begin
        N_REG  <= gnt[GNT_LD] ? LD_REG  : EX_REG;
        REG_IN <= gnt[GNT_LD] ? LD_DATA : EX_DATA;
      end
      PENDING <= (PENDING & ~clr_mask) | set_mask;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then
// randomized producers/decode checked every cycle against a behavioural model.
module tb_wb_arbiter;
  logic        CLK_WB = 1'b0;
  logic        RESET_N = 1'b0;
  logic        EX_VALID = 1'b0;
  logic [2:0]  EX_REG = 3'd0;
  logic [15:0] EX_DATA = 16'd0;
  logic        EX_READY;
  logic        LD_VALID = 1'b0;
  logic [2:0]  LD_REG = 3'd0;
  logic [15:0] LD_DATA = 16'd0;
  logic        LD_READY;
  logic        ISSUE_VALID = 1'b0;
  logic [2:0]  ISSUE_REG = 3'd0;
  logic        ISSUE_STALL;
  logic [7:0]  PENDING;
  logic [2:0]  N_REG;
  logic [15:0] REG_IN;
  logic        REG_WEN;

  // ---------------- clock / reset ----------------
  always #5 CLK_WB = ~CLK_WB;

  wb_arbiter dut (
    .CLK_WB      (CLK_WB),
    .RESET_N     (RESET_N),
    .EX_VALID    (EX_VALID),
    .EX_REG      (EX_REG),
    .EX_DATA     (EX_DATA),
    .EX_READY    (EX_READY),
    .LD_VALID    (LD_VALID),
    .LD_REG      (LD_REG),
    .LD_DATA     (LD_DATA),
    .LD_READY    (LD_READY),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_REG   (ISSUE_REG),
    .ISSUE_STALL (ISSUE_STALL),
    .PENDING     (PENDING),
    .N_REG       (N_REG),
    .REG_IN      (REG_IN),
    .REG_WEN     (REG_WEN)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  bit          m_pend[8];
  int          m_last = 1;        // 0: EX won last transfer, 1: LD won
  bit          m_wen = 1'b0;
  int          m_nreg = 0;
  logic [15:0] m_regin = 16'd0;
  bit          m_ex_acc = 1'b0;
  bit          m_ld_acc = 1'b0;

  // -1 none, 0 EX, 1 LD
  function automatic int exp_winner();
    if (!RESET_N) return -1;
    if (EX_VALID && LD_VALID) return 1 - m_last;
    if (EX_VALID) return 0;
    if (LD_VALID) return 1;
    return -1;
  endfunction

  function automatic logic [7:0] pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  always @(posedge CLK_WB) begin
    int w;
    bit issue_ok;
    w = exp_winner();
    if (!RESET_N) begin
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_last = 1; m_wen = 1'b0; m_nreg = 0; m_regin = 16'd0;
      m_ex_acc = 1'b0; m_ld_acc = 1'b0;
    end else begin
      issue_ok = ISSUE_VALID && !m_pend[ISSUE_REG];
      if (m_wen) m_pend[m_nreg] = 1'b0;
      if (issue_ok) m_pend[ISSUE_REG] = 1'b1;
      m_ex_acc = (w == 0);
      m_ld_acc = (w == 1);
      if (w >= 0) begin
        m_wen   = 1'b1;
        m_nreg  = (w == 1) ? int'(LD_REG) : int'(EX_REG);
        m_regin = (w == 1) ? LD_DATA : EX_DATA;
        m_last  = w;
      end else begin
        m_wen = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int w;
    int wr_reg;
    w = exp_winner();
    chk("ex_ready", EX_READY, (w == 0));
    chk("ld_ready", LD_READY, (w == 1));
    chk("issue_stall", ISSUE_STALL, (RESET_N && ISSUE_VALID && m_pend[ISSUE_REG]));
    chk("reg_wen", REG_WEN, m_wen);
    chk("n_reg", N_REG, m_nreg);
    chk("reg_in", REG_IN, m_regin);
    chk("pending", PENDING, pend_vec());
    if (w >= 0) begin
      wr_reg = (w == 1) ? int'(LD_REG) : int'(EX_REG);
      chk("proto_write_to_idle_reg", m_pend[wr_reg], 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  bit ex_hold = 1'b0;
  bit ld_hold = 1'b0;
  bit gen_en  = 1'b0;

  task automatic cyc();
    @(negedge CLK_WB);
  endtask

  task automatic settle();
    #2;
    compare();
  endtask

  function automatic bit avail(input int r);
    return m_pend[r] && !(ex_hold && int'(EX_REG) == r) &&
           !(ld_hold && int'(LD_REG) == r) && !(m_wen && m_nreg == r);
  endfunction

  function automatic int pick_reg();
    int start;
    start = int'($urandom_range(0, 7));
    for (int k = 0; k < 8; k++) begin
      if (avail((start + k) % 8)) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic rand_drive();
    int r;
    if (!RESET_N) begin
      ex_hold = 1'b0;
      ld_hold = 1'b0;
    end
    if (m_ex_acc) ex_hold = 1'b0;
    if (m_ld_acc) ld_hold = 1'b0;
    RESET_N = !(gen_en && $urandom_range(0, 299) == 0);
    if (!ex_hold && gen_en && $urandom_range(0, 3) != 0) begin
      r = pick_reg();
      if (r >= 0) begin
        ex_hold = 1'b1; EX_REG = 3'(r); EX_DATA = 16'($urandom);
      end
    end
    if (!ld_hold && gen_en && $urandom_range(0, 3) != 0) begin
      r = pick_reg();
      if (r >= 0) begin
        ld_hold = 1'b1; LD_REG = 3'(r); LD_DATA = 16'($urandom);
      end
    end
    EX_VALID    = ex_hold;
    LD_VALID    = ld_hold;
    ISSUE_VALID = gen_en && ($urandom_range(0, 1) == 1);
    ISSUE_REG   = 3'($urandom_range(0, 7));
  endtask

  task automatic idle_inputs();
    EX_VALID = 1'b0; LD_VALID = 1'b0; ISSUE_VALID = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ex_i;
    int ld_i;
    bit drained;
    @(posedge CLK_WB);

    // reset then idle
    cyc(); settle();
    chk("rst_reg_wen", REG_WEN, 0);
    chk("rst_pending", PENDING, 8'h00);
    chk("rst_ex_ready", EX_READY, 0);
    cyc(); RESET_N = 1'b1; settle();
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      chk("idle_reg_wen", REG_WEN, 0);
    end
    chk("idle_pending", PENDING, 8'h00);

    // issue R3 then single EX write
    cyc(); ISSUE_VALID = 1'b1; ISSUE_REG = 3'd3; settle();
    chk("issue3_stall", ISSUE_STALL, 0);
    cyc(); ISSUE_VALID = 1'b0; EX_VALID = 1'b1; EX_REG = 3'd3; EX_DATA = 16'h1234; settle();
    chk("issue3_pending", PENDING, 8'h08);
    chk("wr3_ex_ready", EX_READY, 1);
    cyc(); EX_VALID = 1'b0; settle();
    chk("wr3_n_reg", N_REG, 3);
    chk("wr3_reg_in", REG_IN, 16'h1234);
    chk("wr3_reg_wen", REG_WEN, 1);
    chk("wr3_pending_before_commit", PENDING, 8'h08);
    cyc(); settle();
    chk("wr3_pending_after", PENDING, 8'h00);
    chk("wr3_wen_clear", REG_WEN, 0);

    // simultaneous requests straight after reset: EX wins first tie
    cyc(); RESET_N = 1'b0; settle();
    cyc(); RESET_N = 1'b1; settle();
    cyc(); ISSUE_VALID = 1'b1; ISSUE_REG = 3'd1; settle();
    cyc(); ISSUE_REG = 3'd2; settle();
    cyc(); ISSUE_VALID = 1'b0;
    EX_VALID = 1'b1; EX_REG = 3'd1; EX_DATA = 16'hAAAA;
    LD_VALID = 1'b1; LD_REG = 3'd2; LD_DATA = 16'h5555; settle();
    chk("sim_c1_ex_ready", EX_READY, 1);
    chk("sim_c1_ld_ready", LD_READY, 0);
    chk("sim_pending", PENDING, 8'h06);
    cyc(); EX_VALID = 1'b0; settle();
    chk("sim_c2_ld_ready", LD_READY, 1);
    chk("sim_w1_n_reg", N_REG, 1);
    chk("sim_w1_reg_in", REG_IN, 16'hAAAA);
    chk("sim_w1_wen", REG_WEN, 1);
    cyc(); LD_VALID = 1'b0; settle();
    chk("sim_w2_n_reg", N_REG, 2);
    chk("sim_w2_reg_in", REG_IN, 16'h5555);
    chk("sim_w2_wen", REG_WEN, 1);
    chk("sim_w2_pending", PENDING, 8'h04);
    cyc(); settle();
    chk("sim_done_pending", PENDING, 8'h00);

    // fairness: issue all eight, then both producers stay valid
    for (int i = 0; i < 8; i++) begin
      cyc(); ISSUE_VALID = 1'b1; ISSUE_REG = 3'(i); settle();
    end
    ex_i = 0; ld_i = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      ISSUE_VALID = 1'b0;
      EX_VALID = (ex_i < 4); EX_REG = 3'(ex_i); EX_DATA = 16'(16'h1000 + ex_i);
      LD_VALID = (ld_i < 4); LD_REG = 3'(4 + ld_i); LD_DATA = 16'(16'h2000 + ld_i);
      settle();
      chk("fair_ex_ready", EX_READY, (i % 2 == 0));
      chk("fair_ld_ready", LD_READY, (i % 2 == 1));
      if (EX_READY) ex_i++;
      if (LD_READY) ld_i++;
    end
    cyc(); idle_inputs(); settle();
    cyc(); settle();
    chk("fair_done_pending", PENDING, 8'h00);

    // hazard stall on R5
    cyc(); ISSUE_VALID = 1'b1; ISSUE_REG = 3'd5; settle();
    cyc(); EX_VALID = 1'b1; EX_REG = 3'd5; EX_DATA = 16'hBEEF; settle();
    chk("haz_stall_c1", ISSUE_STALL, 1);
    chk("haz_ex_ready", EX_READY, 1);
    cyc(); EX_VALID = 1'b0; settle();
    chk("haz_stall_commit_cycle", ISSUE_STALL, 1);
    chk("haz_wen", REG_WEN, 1);
    cyc(); settle();
    chk("haz_stall_dropped", ISSUE_STALL, 0);
    chk("haz_pending_cleared", PENDING, 8'h00);
    cyc(); ISSUE_VALID = 1'b0; settle();
    chk("haz_pending_reissued", PENDING, 8'h20);
    cyc(); EX_VALID = 1'b1; settle();
    cyc(); EX_VALID = 1'b0; settle();
    cyc(); settle();
    chk("haz_done_pending", PENDING, 8'h00);

    // reset one edge after an accepted handshake
    cyc(); ISSUE_VALID = 1'b1; ISSUE_REG = 3'd2; settle();
    cyc(); ISSUE_VALID = 1'b0; EX_VALID = 1'b1; EX_REG = 3'd2; EX_DATA = 16'hCAFE; settle();
    chk("mid_ex_ready", EX_READY, 1);
    cyc(); RESET_N = 1'b0; ISSUE_VALID = 1'b1; ISSUE_REG = 3'd2; settle();
    chk("mid_ready_in_reset", EX_READY, 0);
    chk("mid_stall_in_reset", ISSUE_STALL, 0);
    cyc(); RESET_N = 1'b1; idle_inputs(); settle();
    chk("mid_reg_wen", REG_WEN, 0);
    chk("mid_pending", PENDING, 8'h00);

    // randomized traffic
    gen_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cyc(); rand_drive(); settle();
    end

    // drain outstanding requests with a bounded wait
    gen_en = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      cyc(); rand_drive(); settle();
      drained = !ex_hold && !ld_hold && !m_wen;
    end
    chk("drain_timeout", drained, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
